aes_iter_core: RTL and testbench

Iterative AES block-cipher engine that executes one round per clock on a single 128-bit state register. It supports AES-128 and AES-256 through a parameter, and performs both encryption and decryption. Round keys are precomputed once per key load into an internal round-key buffer, so decryption can walk the schedule backwards. It sits between the host command/streaming interface and the combinational per-round AES datapath, and uses valid/ready handshakes on key, input and output channels.

---
 rtl/aes_iter_core.sv | 233 +++++++++++++++++++++++
 tb/tb_aes_iter_core.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_iter_core.sv
// Iterative AES-128/256 encrypt/decrypt engine: one round per clock on a 128-bit state,
// with the full round-key schedule expanded once per key load into a local buffer.
module aes_iter_core #(
  parameter int unsigned KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_valid,
  output logic                key_ready,
  input  logic [KEY_BITS-1:0] key,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_data,
  input  logic                in_decrypt,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_data,
  output logic                out_decrypt,
  output logic                key_loaded
);
  localparam bit          IS256    = (KEY_BITS == 256);
  localparam int unsigned NR       = IS256 ? 14 : 10;
  localparam logic [3:0]  LAST_IDX = 4'(NR);

  if (KEY_BITS != 128 && KEY_BITS != 256) begin : gBadKeyBits
    $error("aes_iter_core: KEY_BITS must be 128 or 256");
  end

  typedef enum logic [2:0] {IDLE, KEYEXP, READY, ROUND, DONE} stateT;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = '0;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254; zero maps to zero, as the S-box needs
  function automatic logic [7:0] gfInv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gmul(r, p);
      p = gmul(p, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gfInv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] invSbox(input logic [7:0] s);
    return gfInv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] subWord(input logic [31:0] w);
    logic [31:0] o;
    for (int k = 0; k < 4; k++) o[31-8*k -: 8] = sbox(w[31-8*k -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] subBytes(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int k = 0; k < 16; k++)
      o[127-8*k -: 8] = inv ? invSbox(s[127-8*k -: 8]) : sbox(s[127-8*k -: 8]);
    return o;
  endfunction

  // Byte 4*c+r holds row r of column c
  function automatic logic [127:0] shiftRows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    int src;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c + 4 - r) % 4 : (c + r) % 4;
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*src+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mixColumns(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [31:0]  coef;
    logic [7:0]   b;
    coef = inv ? 32'h0e0b0d09 : 32'h02030101;
    o    = '0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) begin
        b = '0;
        for (int j = 0; j < 4; j++)
          b = b ^ gmul(s[127-8*(4*c+j) -: 8], coef[31-8*((j-i+4)%4) -: 8]);
        o[127-8*(4*c+i) -: 8] = b;
      end
    end
    return o;
  endfunction

  stateT        stateQ, stateNext;
  logic [127:0] rkBuf [0:NR];
  logic [127:0] dataQ, prevKeyQ, lastKeyQ, baseKey, newKey, roundKey, roundOut;
  logic [31:0]  tempWord, w0, w1, w2, w3;
  logic [7:0]   rconQ;
  logic [3:0]   keyIdxQ, roundQ, rkIdx;
  logic         modeQ, inReadyQ, useRot, keyFire, inFire, outFire;

  assign in_ready = inReadyQ & ~key_valid;
  assign keyFire  = key_valid & key_ready;
  assign inFire   = in_valid & in_ready;
  assign outFire  = out_valid & out_ready;

  // One round key per cycle; AES-256 alternates RotWord+Rcon and SubWord-only steps
  always_comb begin
    useRot   = !IS256 || !keyIdxQ[0];
    tempWord = useRot ? {lastKeyQ[23:0], lastKeyQ[31:24]} : lastKeyQ[31:0];
    tempWord = subWord(tempWord) ^ (useRot ? {rconQ, 24'h000000} : 32'h0);
    baseKey  = IS256 ? prevKeyQ : lastKeyQ;
    w0       = baseKey[127:96] ^ tempWord;
    w1       = baseKey[95:64] ^ w0;
    w2       = baseKey[63:32] ^ w1;
    w3       = baseKey[31:0] ^ w2;
    newKey   = {w0, w1, w2, w3};
  end

  always_comb begin
    rkIdx    = modeQ ? (LAST_IDX - roundQ) : roundQ;
    roundKey = rkBuf[rkIdx];
    roundOut = '0;
    if (!modeQ) begin
      roundOut = shiftRows(subBytes(dataQ, 1'b0), 1'b0);
      if (roundQ != LAST_IDX) roundOut = mixColumns(roundOut, 1'b0);
      roundOut = roundOut ^ roundKey;
    end else begin
      roundOut = subBytes(shiftRows(dataQ, 1'b1), 1'b1) ^ roundKey;
      if (roundQ != LAST_IDX) roundOut = mixColumns(roundOut, 1'b1);
    end
  end

  always_comb begin
    stateNext = stateQ;
    case (stateQ)
      IDLE:    if (keyFire) stateNext = KEYEXP;
      KEYEXP:  if (keyIdxQ == LAST_IDX) stateNext = READY;
      READY:   if (keyFire) stateNext = KEYEXP;
               else if (inFire) stateNext = ROUND;
      ROUND:   if (roundQ == LAST_IDX) stateNext = DONE;
      DONE:    if (outFire) stateNext = READY;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ      <= IDLE;
      key_loaded  <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_decrypt <= 1'b0;
      key_ready   <= 1'b1;
      inReadyQ    <= 1'b0;
      keyIdxQ     <= '0;
      roundQ      <= '0;
      rconQ       <= 8'h01;
      modeQ       <= 1'b0;
      dataQ       <= '0;
      prevKeyQ    <= '0;
      lastKeyQ    <= '0;
    end else begin
      stateQ    <= stateNext;
      key_ready <= (stateNext == IDLE) || (stateNext == READY);
      inReadyQ  <= (stateNext == READY);
      if (keyFire) begin
        key_loaded <= 1'b0;
        keyIdxQ    <= IS256 ? 4'd2 : 4'd1;
        rconQ      <= 8'h01;
        prevKeyQ   <= key[KEY_BITS-1 -: 128];
        lastKeyQ   <= key[127:0];
      end else if (stateQ == KEYEXP) begin
        prevKeyQ <= lastKeyQ;
        lastKeyQ <= newKey;
        keyIdxQ  <= keyIdxQ + 4'd1;
        if (useRot) rconQ <= xtime(rconQ);
        if (keyIdxQ == LAST_IDX) key_loaded <= 1'b1;
      end
      if (inFire) begin
        dataQ  <= in_data ^ (in_decrypt ? rkBuf[LAST_IDX] : rkBuf[0]);
        modeQ  <= in_decrypt;
        roundQ <= 4'd1;
      end else if (stateQ == ROUND) begin
        dataQ <= roundOut;
        if (roundQ == LAST_IDX) begin
          out_valid   <= 1'b1;
          out_data    <= roundOut;
          out_decrypt <= modeQ;
        end else begin
          roundQ <= roundQ + 4'd1;
        end
      end
      if (outFire) out_valid <= 1'b0;
    end
  end

  // Schedule storage needs no reset: key_loaded gates every use of it
  always_ff @(posedge clk) begin
    if (keyFire) begin
      rkBuf[0] <= key[KEY_BITS-1 -: 128];
      if (IS256) rkBuf[1] <= key[127:0];
    end else if (stateQ == KEYEXP) begin
      rkBuf[keyIdxQ] <= newKey;
    end
  end
endmodule

// File: tb/tb_aes_iter_core.sv
// Scoreboard bench for aes_iter_core: an AES-128 and an AES-256 instance driven with FIPS-197 vectors.
module tb_aes_iter_core;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] KEY_C3 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;

  typedef struct {
    logic [127:0] data;
    logic         dec;
    int unsigned  acc;
  } expT;

  logic clk = 1'b0;
  logic rstN;
  logic [1:0] keyValid, keyReady, inValid, inReady, inDecrypt;
  logic [1:0] outValid, outReady, outDecrypt, keyLoaded;
  logic [1:0][127:0] inData, outData;
  logic [127:0] key128;
  logic [255:0] key256;
  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;
  expT q0[$];
  expT q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_iter_core #(.KEY_BITS(128)) dut128 (
    .clk(clk), .rst_n(rstN),
    .key_valid(keyValid[0]), .key_ready(keyReady[0]), .key(key128),
    .in_valid(inValid[0]), .in_ready(inReady[0]), .in_data(inData[0]), .in_decrypt(inDecrypt[0]),
    .out_valid(outValid[0]), .out_ready(outReady[0]), .out_data(outData[0]),
    .out_decrypt(outDecrypt[0]), .key_loaded(keyLoaded[0])
  );

  aes_iter_core #(.KEY_BITS(256)) dut256 (
    .clk(clk), .rst_n(rstN),
    .key_valid(keyValid[1]), .key_ready(keyReady[1]), .key(key256),
    .in_valid(inValid[1]), .in_ready(inReady[1]), .in_data(inData[1]), .in_decrypt(inDecrypt[1]),
    .out_valid(outValid[1]), .out_ready(outReady[1]), .out_data(outData[1]),
    .out_decrypt(outDecrypt[1]), .key_loaded(keyLoaded[1])
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic int qSize(input int idx);
    return (idx == 0) ? q0.size() : q1.size();
  endfunction

  // Monitor: each rising out_valid is matched against the oldest expectation
  always @(negedge clk) begin
    static logic [1:0] prevOv = 2'b00;
    expT e;
    for (int i = 0; i < 2; i++) begin
      if (outValid[i] && !prevOv[i]) begin
        if (qSize(i) == 0) begin
          checks++;
          errors++;
          $display("FAIL dut%0d_unexpected_output: actual %0h required none", i, outData[i]);
        end else begin
          e = (i == 0) ? q0.pop_front() : q1.pop_front();
          chk($sformatf("dut%0d_out_data", i), outData[i], e.data);
          chk($sformatf("dut%0d_out_decrypt", i), 128'(outDecrypt[i]), 128'(e.dec));
          chk($sformatf("dut%0d_latency", i), 128'(cyc - e.acc), 128'((i == 0) ? 10 : 14));
        end
      end
    end
    prevOv = outValid;
  end

  task automatic loadKey(input int idx, input logic [255:0] k);
    int n;
    int unsigned acc;
    @(negedge clk);
    if (idx == 0) key128 = k[127:0];
    else key256 = k;
    keyValid[idx] = 1'b1;
    #1;
    n = 0;
    while (!keyReady[idx] && n < 50) begin @(negedge clk); n++; end
    chk($sformatf("dut%0d_key_ready_wait", idx), 128'(keyReady[idx]), 128'(1));
    acc = cyc + 1;
    @(negedge clk);
    keyValid[idx] = 1'b0;
    n = 0;
    while (!keyLoaded[idx] && n < 50) begin @(negedge clk); n++; end
    chk($sformatf("dut%0d_keyexp_cycles", idx), 128'(cyc - acc), 128'((idx == 0) ? 10 : 13));
  endtask

  task automatic sendBlock(input int idx, input logic [127:0] d, input logic dec,
                           input logic [127:0] expOut, output int unsigned acc);
    int n;
    expT e;
    @(negedge clk);
    inData[idx]    = d;
    inDecrypt[idx] = dec;
    inValid[idx]   = 1'b1;
    #1;
    n = 0;
    while (!inReady[idx] && n < 50) begin @(negedge clk); n++; end
    chk($sformatf("dut%0d_in_ready_wait", idx), 128'(inReady[idx]), 128'(1));
    acc = cyc + 1;
    e.data = expOut;
    e.dec  = dec;
    e.acc  = acc;
    if (idx == 0) q0.push_back(e);
    else q1.push_back(e);
    @(negedge clk);
    inValid[idx] = 1'b0;
  endtask

  task automatic waitDrain(input int idx);
    int n = 0;
    while ((qSize(idx) != 0 || outValid[idx]) && n < 100) begin @(negedge clk); n++; end
    chk($sformatf("dut%0d_drain", idx), 128'(qSize(idx)), 128'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned acc1, acc2;
    int n;
    rstN = 1'b0;
    keyValid = '0; inValid = '0; inDecrypt = '0; outReady = 2'b11;
    inData = '0; key128 = '0; key256 = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("dut%0d_rst_key_loaded", i), 128'(keyLoaded[i]), 128'(0));
      chk($sformatf("dut%0d_rst_out_valid", i), 128'(outValid[i]), 128'(0));
      chk($sformatf("dut%0d_rst_out_data", i), outData[i], 128'(0));
      chk($sformatf("dut%0d_rst_out_decrypt", i), 128'(outDecrypt[i]), 128'(0));
      chk($sformatf("dut%0d_rst_in_ready", i), 128'(inReady[i]), 128'(0));
      chk($sformatf("dut%0d_rst_key_ready", i), 128'(keyReady[i]), 128'(1));
    end
    rstN = 1'b1;

    // Block offered before any key: must be ignored
    inValid[0] = 1'b1;
    inData[0]  = PT_B;
    repeat (4) begin
      @(negedge clk);
      chk("nokey_in_ready", 128'(inReady[0]), 128'(0));
      chk("nokey_key_loaded", 128'(keyLoaded[0]), 128'(0));
    end
    inValid[0] = 1'b0;

    // App. B encrypt, back-to-back to measure throughput
    loadKey(0, 256'(KEY_B));
    sendBlock(0, PT_B, 1'b0, CT_B, acc1);
    sendBlock(0, PT_B, 1'b0, CT_B, acc2);
    chk("throughput_spacing", 128'(acc2 - acc1), 128'(12));
    waitDrain(0);

    // C.1 decrypt
    loadKey(0, 256'(KEY_C1));
    sendBlock(0, CT_C1, 1'b1, PT_C, acc1);
    waitDrain(0);

    // Backpressure: 7 stalled cycles, handshake on the 8th
    outReady[0] = 1'b0;
    sendBlock(0, PT_C, 1'b0, CT_C1, acc1);
    n = 0;
    while (!outValid[0] && n < 50) begin @(negedge clk); n++; end
    for (int k = 0; k < 7; k++) begin
      chk("bp_out_valid", 128'(outValid[0]), 128'(1));
      chk("bp_out_data", outData[0], CT_C1);
      chk("bp_in_ready", 128'(inReady[0]), 128'(0));
      chk("bp_key_ready", 128'(keyReady[0]), 128'(0));
      @(negedge clk);
    end
    outReady[0] = 1'b1;
    @(negedge clk);
    chk("bp_after_out_valid", 128'(outValid[0]), 128'(0));
    chk("bp_after_in_ready", 128'(inReady[0]), 128'(1));
    chk("bp_after_key_ready", 128'(keyReady[0]), 128'(1));
    chk("bp_after_out_data_kept", outData[0], CT_C1);

    // Key and block offered together in READY: key wins
    key128 = KEY_B;
    keyValid[0] = 1'b1;
    inValid[0] = 1'b1;
    inData[0] = PT_B;
    inDecrypt[0] = 1'b0;
    #1;
    chk("collide_in_ready", 128'(inReady[0]), 128'(0));
    chk("collide_key_ready", 128'(keyReady[0]), 128'(1));
    @(negedge clk);
    keyValid[0] = 1'b0;
    inValid[0] = 1'b0;
    chk("collide_key_loaded", 128'(keyLoaded[0]), 128'(0));
    chk("collide_keyexp_key_ready", 128'(keyReady[0]), 128'(0));
    n = 0;
    while (!keyLoaded[0] && n < 50) begin @(negedge clk); n++; end
    chk("collide_reload_done", 128'(keyLoaded[0]), 128'(1));
    chk("collide_ready_in_ready", 128'(inReady[0]), 128'(1));

    // Reset in the middle of round 5
    sendBlock(0, PT_B, 1'b0, CT_B, acc1);
    repeat (4) @(negedge clk);
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    q0.delete();
    chk("midrst_out_valid", 128'(outValid[0]), 128'(0));
    chk("midrst_key_loaded", 128'(keyLoaded[0]), 128'(0));
    chk("midrst_key_ready", 128'(keyReady[0]), 128'(1));
    chk("midrst_in_ready", 128'(inReady[0]), 128'(0));
    repeat (16) @(negedge clk);
    loadKey(0, 256'(KEY_B));
    sendBlock(0, PT_B, 1'b0, CT_B, acc1);
    waitDrain(0);

    // AES-256 C.3 encrypt then decrypt back
    loadKey(1, KEY_C3);
    sendBlock(1, PT_C, 1'b0, CT_C3, acc1);
    waitDrain(1);
    sendBlock(1, CT_C3, 1'b1, PT_C, acc1);
    waitDrain(1);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
